// File: rtl/multicycle_control_if.sv
// Datapath-facing bundle of the multicycle sequencer: fetched opcode and ALU zero
// flag in, write enables and mux selects out.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       pcWrite;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       regDst;
    logic       aluSrc;
    logic       regWrite;
    logic       jump;
    logic       branchTaken;
    logic [1:0] aluOp;

    modport master (
        input  opcode, zero,
        output pcWrite, irWrite, memRead, memWrite, memtoReg, regDst,
               aluSrc, regWrite, jump, branchTaken, aluOp
    );

    modport slave (
        output opcode, zero,
        input  pcWrite, irWrite, memRead, memWrite, memtoReg, regDst,
               aluSrc, regWrite, jump, branchTaken, aluOp
    );
endinterface

// File: rtl/multicycle_control.sv
// Per-instruction MIPS control FSM with free-run and single-step modes.
// Define MC_INSTR_COUNT_EN to build the retired-instruction counter; otherwise instr_count is 0.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_control_if.master bus,
    input  logic                 run,
    input  logic                 step,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 illegal,
    output logic [CNT_W-1:0]     instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t     cur;
    state_t     end_state;
    logic       step_q;
    logic [5:0] op_q;
    logic       last;
    logic       op_legal;

    logic       pc_write, ir_write, mem_read, mem_write, mem_to_reg;
    logic       reg_dst, alu_src, reg_write, jump_sel, branch_taken;
    logic [1:0] alu_op;

    assign op_legal  = (bus.opcode == OP_R)  || (bus.opcode == OP_LW)  ||
                       (bus.opcode == OP_SW) || (bus.opcode == OP_BEQ) ||
                       (bus.opcode == OP_J)  || (bus.opcode == OP_ADDI);
    assign end_state = run ? FETCH : IDLE;

    // DECODE must look at the live opcode; later states only trust the latched copy.
    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dst      = 1'b0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        jump_sel     = 1'b0;
        branch_taken = 1'b0;
        alu_op       = 2'b00;
        last         = 1'b0;
        case (cur)
            FETCH: ir_write = 1'b1;
            DECODE: begin
                if (bus.opcode == OP_J) begin
                    jump_sel = 1'b1;
                    pc_write = 1'b1;
                    last     = 1'b1;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_R:              alu_op = 2'b10;
                    OP_ADDI, OP_LW, OP_SW: alu_src = 1'b1;
                    OP_BEQ: begin
                        alu_op       = 2'b01;
                        pc_write     = 1'b1;
                        branch_taken = bus.zero;
                        last         = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                alu_src = 1'b1;
                if (op_q == OP_LW) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                    pc_write  = 1'b1;
                    last      = 1'b1;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                reg_dst    = (op_q == OP_R);
                mem_to_reg = (op_q == OP_LW);
                alu_src    = (op_q == OP_ADDI) || (op_q == OP_LW);
                last       = 1'b1;
            end
            default: ;
        endcase
    end

    // Suppressed while reset is high so an aborted instruction never writes anything.
    assign bus.pcWrite     = pc_write     & ~reset;
    assign bus.irWrite     = ir_write     & ~reset;
    assign bus.memRead     = mem_read     & ~reset;
    assign bus.memWrite    = mem_write    & ~reset;
    assign bus.memtoReg    = mem_to_reg   & ~reset;
    assign bus.regDst      = reg_dst      & ~reset;
    assign bus.aluSrc      = alu_src      & ~reset;
    assign bus.regWrite    = reg_write    & ~reset;
    assign bus.jump        = jump_sel     & ~reset;
    assign bus.branchTaken = branch_taken & ~reset;
    assign bus.aluOp       = reset ? 2'b00 : alu_op;

    assign state = cur;
    assign busy  = (cur != IDLE) && (cur != HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            cur     <= IDLE;
            step_q  <= 1'b0;
            op_q    <= 6'd0;
            illegal <= 1'b0;
        end else begin
            step_q <= step;
            case (cur)
                IDLE:   if (run || (step && !step_q)) cur <= FETCH;
                FETCH:  cur <= DECODE;
                DECODE: begin
                    op_q <= bus.opcode;
                    if (!op_legal) begin
                        illegal <= 1'b1;
                        cur     <= HALT;
                    end else if (last) begin
                        cur <= end_state;
                    end else begin
                        cur <= EXEC;
                    end
                end
                EXEC: begin
                    if (last)                               cur <= end_state;
                    else if ((op_q == OP_LW) || (op_q == OP_SW)) cur <= MEM;
                    else                                    cur <= WB;
                end
                MEM:     cur <= last ? end_state : WB;
                WB:      cur <= end_state;
                HALT:    cur <= HALT;
                default: cur <= IDLE;
            endcase
        end
    end

`ifdef MC_INSTR_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset)     count_q <= '0;
        else if (last) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control, built with a 4-bit counter so wrap is reachable.
module tb_multicycle_control;

   localparam int CNT_W = 4;
`ifdef MC_INSTR_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   logic             clock;
   logic             reset;
   logic             run;
   logic             step;
   logic [2:0]       state;
   logic             busy;
   logic             illegal;
   logic [CNT_W-1:0] instr_count;

   int testCount;
   int failCount;

   multicycle_control_if bus();

   multicycle_control #(.CNT_W(CNT_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus.master),
      .run         (run),
      .step        (step),
      .state       (state),
      .busy        (busy),
      .illegal     (illegal),
      .instr_count (instr_count)
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Packs the control outputs as {pcWrite,irWrite,memRead,memWrite,memtoReg,regDst,aluSrc,regWrite,jump,branchTaken,aluOp}.
   function automatic logic [11:0] ctrlVec();
      return {bus.pcWrite, bus.irWrite, bus.memRead, bus.memWrite, bus.memtoReg,
              bus.regDst, bus.aluSrc, bus.regWrite, bus.jump, bus.branchTaken, bus.aluOp};
   endfunction

   // Counter value expected for n retired instructions in the current build.
   function automatic logic [CNT_W-1:0] expCount(int n);
      return COUNT_EN ? CNT_W'(n % (1 << CNT_W)) : '0;
   endfunction

   // Drives the inputs, then advances one clock and settles just past the edge.
   task automatic applyStimulus(input logic rst, input logic r, input logic s,
                                input logic [5:0] op, input logic z);
      reset      = rst;
      run        = r;
      step       = s;
      bus.opcode = op;
      bus.zero   = z;
      @(posedge clock);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkCycle(input string tag, input logic [2:0] expState,
                             input logic [11:0] expCtrl);
      checkOutput({tag, "_state"}, 32'(state), 32'(expState));
      checkOutput({tag, "_ctrl"}, 32'(ctrlVec()), 32'(expCtrl));
   endtask

   // One linear directed sequence; expected values are hand-derived per state.
   initial begin
      testCount = 0;
      failCount = 0;

      applyStimulus(1, 0, 0, OP_R, 0);
      applyStimulus(1, 0, 0, OP_R, 0);
      checkCycle("reset", 3'd0, 12'h000);
      checkOutput("reset_illegal", 32'(illegal), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_count", 32'(instr_count), 32'(expCount(0)));

      // R-type in free-run mode: 1,2,3,5 and straight back to FETCH.
      applyStimulus(0, 1, 0, OP_R, 0);
      checkCycle("r_fetch", 3'd1, 12'h400);
      checkOutput("r_busy", 32'(busy), 32'd1);
      applyStimulus(0, 1, 0, OP_R, 0);
      checkCycle("r_decode", 3'd2, 12'h000);
      applyStimulus(0, 1, 0, OP_R, 0);
      checkCycle("r_exec", 3'd3, 12'h002);
      applyStimulus(0, 1, 0, OP_R, 0);
      checkCycle("r_wb", 3'd5, 12'h850);
      checkOutput("r_count_wb", 32'(instr_count), 32'(expCount(0)));
      applyStimulus(0, 1, 0, OP_R, 0);
      checkCycle("r_fetch2", 3'd1, 12'h400);
      checkOutput("r_count1", 32'(instr_count), 32'(expCount(1)));
      applyStimulus(0, 1, 0, OP_R, 0);
      applyStimulus(0, 1, 0, OP_R, 0);
      checkCycle("r_exec2", 3'd3, 12'h002);
      applyStimulus(0, 0, 0, OP_R, 0);
      checkCycle("r_wb2", 3'd5, 12'h850);
      applyStimulus(0, 0, 0, OP_R, 0);
      checkCycle("r_idle", 3'd0, 12'h000);
      checkOutput("r_count2", 32'(instr_count), 32'(expCount(2)));

      // lw in step mode, with a second press during the instruction.
      applyStimulus(0, 0, 1, OP_LW, 0);
      checkCycle("lw_fetch", 3'd1, 12'h400);
      applyStimulus(0, 0, 1, OP_LW, 0);
      checkCycle("lw_decode", 3'd2, 12'h000);
      applyStimulus(0, 0, 0, OP_LW, 0);
      checkCycle("lw_exec", 3'd3, 12'h020);
      applyStimulus(0, 0, 1, OP_LW, 0);
      checkCycle("lw_mem", 3'd4, 12'h220);
      applyStimulus(0, 0, 1, OP_LW, 0);
      checkCycle("lw_wb", 3'd5, 12'h8B0);
      applyStimulus(0, 0, 1, OP_LW, 0);
      checkCycle("lw_idle", 3'd0, 12'h000);
      applyStimulus(0, 0, 1, OP_LW, 0);
      checkCycle("lw_no_queue", 3'd0, 12'h000);
      checkOutput("lw_count", 32'(instr_count), 32'(expCount(3)));
      applyStimulus(0, 0, 0, OP_LW, 0);

      // beq taken, then not taken; three cycles each.
      applyStimulus(0, 0, 1, OP_BEQ, 1);
      checkCycle("beq1_fetch", 3'd1, 12'h400);
      applyStimulus(0, 0, 0, OP_BEQ, 1);
      applyStimulus(0, 0, 0, OP_BEQ, 1);
      checkCycle("beq1_exec", 3'd3, 12'h805);
      applyStimulus(0, 0, 0, OP_BEQ, 1);
      checkCycle("beq1_idle", 3'd0, 12'h000);
      applyStimulus(0, 0, 1, OP_BEQ, 0);
      applyStimulus(0, 0, 0, OP_BEQ, 0);
      applyStimulus(0, 0, 0, OP_BEQ, 0);
      checkCycle("beq0_exec", 3'd3, 12'h801);
      applyStimulus(0, 0, 0, OP_BEQ, 0);
      checkCycle("beq0_idle", 3'd0, 12'h000);
      checkOutput("beq_count", 32'(instr_count), 32'(expCount(5)));

      // sw aborted by reset in its MEM cycle.
      applyStimulus(0, 0, 1, OP_SW, 0);
      applyStimulus(0, 0, 0, OP_SW, 0);
      applyStimulus(0, 0, 0, OP_SW, 0);
      checkCycle("sw_exec", 3'd3, 12'h020);
      applyStimulus(0, 0, 0, OP_SW, 0);
      checkCycle("sw_mem", 3'd4, 12'h920);
      reset = 1'b1;
      #1;
      checkOutput("sw_rst_memWrite", 32'(bus.memWrite), 32'd0);
      applyStimulus(1, 0, 0, OP_SW, 0);
      checkCycle("sw_rst_idle", 3'd0, 12'h000);
      checkOutput("sw_rst_count", 32'(instr_count), 32'(expCount(0)));

      // addi single step.
      applyStimulus(0, 0, 1, OP_ADDI, 0);
      applyStimulus(0, 0, 0, OP_ADDI, 0);
      applyStimulus(0, 0, 0, OP_ADDI, 0);
      checkCycle("addi_exec", 3'd3, 12'h020);
      applyStimulus(0, 0, 0, OP_ADDI, 0);
      checkCycle("addi_wb", 3'd5, 12'h830);
      applyStimulus(0, 0, 0, OP_ADDI, 0);
      checkCycle("addi_idle", 3'd0, 12'h000);
      checkOutput("addi_count", 32'(instr_count), 32'(expCount(1)));

      // Seventeen jumps back to back wrap the 4-bit counter to 1.
      applyStimulus(1, 0, 0, OP_J, 0);
      for (int i = 0; i < 17; i++) begin
         applyStimulus(0, 1, 0, OP_J, 0);
         if (i == 0) checkCycle("j_fetch", 3'd1, 12'h400);
         applyStimulus(0, 1, 0, OP_J, 0);
         if (i == 0) checkCycle("j_decode", 3'd2, 12'h808);
      end
      applyStimulus(0, 0, 0, OP_J, 0);
      checkCycle("j_idle", 3'd0, 12'h000);
      checkOutput("j_count_wrap", 32'(instr_count), 32'(expCount(17)));

      // Illegal opcode halts until reset.
      applyStimulus(0, 1, 0, OP_BAD, 0);
      applyStimulus(0, 1, 0, OP_BAD, 0);
      checkCycle("bad_decode", 3'd2, 12'h000);
      applyStimulus(0, 1, 0, OP_BAD, 0);
      checkCycle("bad_halt", 3'd6, 12'h000);
      checkOutput("bad_illegal", 32'(illegal), 32'd1);
      checkOutput("bad_busy", 32'(busy), 32'd0);
      applyStimulus(0, 1, 1, OP_R, 0);
      applyStimulus(0, 0, 0, OP_R, 0);
      applyStimulus(0, 0, 1, OP_R, 0);
      checkCycle("bad_stuck", 3'd6, 12'h000);
      checkOutput("bad_sticky", 32'(illegal), 32'd1);
      applyStimulus(1, 0, 0, OP_R, 0);
      checkCycle("bad_reset", 3'd0, 12'h000);
      checkOutput("bad_reset_illegal", 32'(illegal), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
